// File: rtl/sump_cmd_deframer.sv
// sump_cmd_deframer: turns the received byte stream into SUMP commands for
// the analyzer core (opcode, config_data, one-cycle execute).
// Short commands are one byte (bit7 = 0); long commands are an opcode byte
// (bit7 = 1) followed by four payload bytes, least significant first.
// Optional feature macro: SUMP_CMD_TIMEOUT_EN adds an inter-byte silence timer
// that discards a stalled long frame and pulses timeout_evt. Without it a long
// frame waits indefinitely and timeout_evt is tied low.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | between commands; next byte is an opcode
// ST_DATA | long opcode seen; collecting the 4 payload bytes
module sump_cmd_deframer #(
  parameter int unsigned     TMR_W          = 24,
  parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        frame_busy,
  output logic        timeout_evt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_shadow_op;
  logic [31:0] r_shadow_data;
  logic [7:0]  r_opcode;
  logic [31:0] r_config_data;
  logic        r_execute;

  logic        w_short_cmd;
  logic        w_frame_start;
  logic        w_store_byte;
  logic        w_frame_done;
  logic        w_tmo_hit;

`ifdef SUMP_CMD_TIMEOUT_EN
  logic [TMR_W-1:0] r_timer;
  logic             r_timeout_evt;

  // Silence timer counts down from TIMEOUT_CYCLES-1; reaching zero on a quiet
  // cycle means TIMEOUT_CYCLES clocks have passed since the last frame byte.
  assign w_tmo_hit = (r_state == ST_DATA) && !rx_valid && (r_timer == '0);

  // Reload on frame entry and every accepted byte, count down while silent.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_frame_start || (r_state == ST_DATA && rx_valid)) begin
      r_timer <= TIMEOUT_CYCLES - 1'b1;
    end else if (r_state == ST_DATA && !w_tmo_hit) begin
      r_timer <= r_timer - 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  // One-cycle notification that a partial frame was dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_timeout_evt <= 1'b0;
    end else begin
      r_timeout_evt <= w_tmo_hit;
    end
  end

  assign timeout_evt = r_timeout_evt;
`else
  logic w_unused_tmo_cfg;

  assign w_tmo_hit        = 1'b0;
  assign timeout_evt      = 1'b0;
  assign w_unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    w_state_nxt   = r_state;
    w_short_cmd   = 1'b0;
    w_frame_start = 1'b0;
    w_store_byte  = 1'b0;
    w_frame_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            w_frame_start = 1'b1;
            w_state_nxt   = ST_DATA;
          end else begin
            w_short_cmd = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          w_store_byte = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shadow opcode/payload assembly; outputs stay untouched until completion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_byte_cnt    <= 2'd0;
      r_shadow_op   <= 8'd0;
      r_shadow_data <= 32'd0;
    end else if (w_frame_start) begin
      r_byte_cnt    <= 2'd0;
      r_shadow_op   <= rx_data;
      r_shadow_data <= 32'd0;
    end else if (w_store_byte) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shadow_data[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
    end
  end

  // Command outputs: updated only when a command completes, held otherwise.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_opcode      <= 8'd0;
      r_config_data <= 32'd0;
      r_execute     <= 1'b0;
    end else begin
      r_execute <= w_short_cmd || w_frame_done;
      if (w_short_cmd) begin
        r_opcode      <= rx_data;
        r_config_data <= 32'd0;
      end else if (w_frame_done) begin
        r_opcode      <= r_shadow_op;
        r_config_data <= {rx_data, r_shadow_data[23:0]};
      end
    end
  end

  assign opcode      = r_opcode;
  assign config_data = r_config_data;
  assign execute     = r_execute;
  assign frame_busy  = (r_state == ST_DATA);

endmodule
